// File: rtl/fetch_ctrl_r32i.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_r32i
// Instruction-fetch and branch-redirect controller for the RV32I core.
// Owns the program counter, runs a single-outstanding request/ack handshake
// with instruction memory, presents fetched words to decode via valid/ready,
// and redirects on taken branches/jumps while killing wrong-path fetches.
//
// Configuration macro: MISALIGN_TRAP_EN
//   defined   : a taken redirect to a non word-aligned target raises trap,
//               parks the controller in HALT (left only through reset).
//   undefined : redirect targets are forced to word alignment, no trap port.
//
// Ports
//   clock, reset                  rising-edge clock, async active-low reset
//   imem_req/imem_addr            fetch request and address (= ProgAddr)
//   imem_ack/imem_data            memory response and instruction word
//   instr_valid/instr/instr_pc    instruction offered to decode
//   instr_ready                   decode accepts the offered instruction
//   BranchControl, Jump           execute holds a branch / unconditional jump
//   PCBranchType                  funct3 of the branch
//   EQ, NE, LT, LTU, GE, GEU      comparator flags from execute
//   BranchBase, BranchOffset      redirect target = base + offset
//   ProgAddr                      current program counter
//   flush                         one-cycle pulse killing younger instructions
//   trap (MISALIGN_TRAP_EN only)  sticky misaligned-redirect indication
// -----------------------------------------------------------------------------
module fetch_ctrl_r32i #(
    parameter int               dataW      = 32,
    parameter logic [dataW-1:0] RESET_ADDR = '0
) (
    input  logic             clock,
    input  logic             reset,
    output logic             imem_req,
    output logic [dataW-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_data,
    output logic             instr_valid,
    output logic [31:0]      instr,
    output logic [dataW-1:0] instr_pc,
    input  logic             instr_ready,
    input  logic             BranchControl,
    input  logic             Jump,
    input  logic [2:0]       PCBranchType,
    input  logic             EQ,
    input  logic             NE,
    input  logic             LT,
    input  logic             LTU,
    input  logic             GE,
    input  logic             GEU,
    input  logic [dataW-1:0] BranchBase,
    input  logic [dataW-1:0] BranchOffset,
    output logic [dataW-1:0] ProgAddr,
`ifdef MISALIGN_TRAP_EN
    output logic             trap,
`endif
    output logic             flush
);

    // S_HALT is only ever entered when the misalignment trap is built in.
    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HOLD,
        S_DRAIN,
        S_HALT
    } state_t;

    state_t           r_state;
    logic             r_imem_req;
    logic             r_instr_valid;
    logic [31:0]      r_instr;
    logic [dataW-1:0] r_instr_pc;
    logic [dataW-1:0] r_prog_addr;
    logic             r_flush;

    logic             w_cond;
    logic             w_taken;
    logic             w_redirect;
    logic [dataW-1:0] w_sum;
    logic [dataW-1:0] w_target;

    // Branch condition selected by funct3; codes 010/011 never take.
    always_comb begin
        w_cond = 1'b0;
        case (PCBranchType)
            3'b000:  w_cond = EQ;
            3'b001:  w_cond = NE;
            3'b100:  w_cond = LT;
            3'b101:  w_cond = GE;
            3'b110:  w_cond = LTU;
            3'b111:  w_cond = GEU;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_taken    = Jump | (BranchControl & w_cond);
    // Once halted nothing but reset may move the PC.
    assign w_redirect = w_taken && (r_state != S_HALT);
    assign w_sum      = BranchBase + BranchOffset;

`ifdef MISALIGN_TRAP_EN
    logic r_trap;
    logic w_misaligned;
    assign w_target     = w_sum;
    assign w_misaligned = |w_sum[1:0];
    assign trap         = r_trap;
`else
    assign w_target = w_sum & ~{{(dataW-2){1'b0}}, 2'b11};
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_prog_addr   <= RESET_ADDR;
            r_flush       <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            r_trap        <= 1'b0;
`endif
        end else begin
            r_flush <= 1'b0;
            if (w_redirect) begin
                r_prog_addr   <= w_target;
                r_instr_valid <= 1'b0;
                r_flush       <= 1'b1;
`ifdef MISALIGN_TRAP_EN
                if (w_misaligned) begin
                    r_trap     <= 1'b1;
                    r_imem_req <= 1'b0;
                    r_state    <= S_HALT;
                end else
`endif
                // A request still in flight must be drained before the
                // target may be fetched. An ack arriving on this very edge
                // completes that request, so the target is fetched directly
                // (this also keeps DRAIN from waiting on an ack that was
                // already consumed).
                if ((r_state == S_REQ || r_state == S_DRAIN) && !imem_ack) begin
                    r_state    <= S_DRAIN;
                    r_imem_req <= 1'b0;
                end else begin
                    r_state    <= S_REQ;
                    r_imem_req <= 1'b1;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state    <= S_REQ;
                        r_imem_req <= 1'b1;
                    end
                    S_REQ: begin
                        if (imem_ack) begin
                            r_instr       <= imem_data;
                            r_instr_pc    <= r_prog_addr;
                            r_instr_valid <= 1'b1;
                            r_imem_req    <= 1'b0;
                            r_state       <= S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (instr_ready) begin
                            r_instr_valid <= 1'b0;
                            r_prog_addr   <= r_prog_addr + dataW'(4);
                            r_imem_req    <= 1'b1;
                            r_state       <= S_REQ;
                        end
                    end
                    S_DRAIN: begin
                        // The response to the abandoned request is dropped.
                        if (imem_ack) begin
                            r_imem_req <= 1'b1;
                            r_state    <= S_REQ;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_prog_addr;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign ProgAddr    = r_prog_addr;
    assign flush       = r_flush;

endmodule

// File: tb/tb_fetch_ctrl_r32i.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl_r32i
// Self-checking bench for fetch_ctrl_r32i: directed scenarios followed by a
// randomized run checked against a rule-level reference (PC bookkeeping,
// kill tracking of in-flight memory requests, branch decisions computed from
// the real operands rather than from the flags).
// -----------------------------------------------------------------------------
module tb_fetch_ctrl_r32i;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        BranchControl = 1'b0;
    logic        Jump = 1'b0;
    logic [2:0]  PCBranchType = 3'b000;
    logic        EQ = 1'b0, NE = 1'b0, LT = 1'b0, LTU = 1'b0, GE = 1'b0, GEU = 1'b0;
    logic [31:0] BranchBase = '0;
    logic [31:0] BranchOffset = '0;
    logic [31:0] ProgAddr;
    logic        flush;
`ifdef MISALIGN_TRAP_EN
    logic        trap;
`endif

    always #5 clock = ~clock;

    fetch_ctrl_r32i #(.dataW(32), .RESET_ADDR(32'h0000_0000)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .BranchControl(BranchControl), .Jump(Jump), .PCBranchType(PCBranchType),
        .EQ(EQ), .NE(NE), .LT(LT), .LTU(LTU), .GE(GE), .GEU(GEU),
        .BranchBase(BranchBase), .BranchOffset(BranchOffset),
        .ProgAddr(ProgAddr),
`ifdef MISALIGN_TRAP_EN
        .trap(trap),
`endif
        .flush(flush)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Instruction memory model: one outstanding request, fixed or random latency.
    bit          mem_busy = 0;
    bit          mem_new = 0;
    bit          mem_rand_lat = 0;
    int          mem_lat = 2;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    logic [31:0] ack_addr = '0;

    // Values seen just before the most recent clock edge.
    logic        pre_valid, pre_ready, pre_ack, pre_busy;
    logic [31:0] pre_instr, pre_ipc, pre_ack_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    // Branch decision from the actual operands.
    function automatic bit branch_ok(input logic [2:0] ty, input logic [31:0] a, input logic [31:0] b);
        case (ty)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) < $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic cycle();
        pre_valid = instr_valid; pre_ready = instr_ready; pre_ack = imem_ack;
        pre_busy = mem_busy; pre_instr = instr; pre_ipc = instr_pc; pre_ack_addr = ack_addr;
        @(posedge clock); #1;
        mem_new = 0;
        imem_ack = 1'b0;
        imem_data = $urandom;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_ack = 1'b1;
                imem_data = mem_word(mem_addr);
                ack_addr = mem_addr;
                mem_busy = 0;
            end
        end else if (imem_req) begin
            mem_busy = 1;
            mem_new = 1;
            mem_addr = imem_addr;
            mem_cnt = mem_rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
        end
    endtask

    task automatic clr_branch();
        BranchControl = 0; Jump = 0; PCBranchType = 3'b000;
        {EQ, NE, LT, LTU, GE, GEU} = 6'b0;
        BranchBase = '0; BranchOffset = '0;
    endtask

    task automatic do_reset();
        clr_branch();
        instr_ready = 0;
        reset = 1'b0;
        mem_busy = 0; imem_ack = 1'b0; mem_rand_lat = 0; mem_lat = 2;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic wait_valid(output bit ok);
        for (int n = 0; n < 50 && !instr_valid; n++) cycle();
        ok = instr_valid;
    endtask

    task automatic test_reset();
        bit ok;
        do_reset();
        mem_lat = 1;
        instr_ready = 1;
        wait_valid(ok);
        cycle();
        instr_ready = 0;
        wait_valid(ok);
        if (ok !== 1'b1) begin n_errors++; $display("FAIL reset_prefill_timeout valid=%0b want 1", instr_valid); end
        n_checks++;
        #2 reset = 1'b0;
        #1;
        if (ProgAddr !== 32'h0) begin n_errors++; $display("FAIL reset_pc got=%08h want=00000000", ProgAddr); end
        n_checks++;
        if (imem_req !== 1'b0) begin n_errors++; $display("FAIL reset_req got=%0b want=0", imem_req); end
        n_checks++;
        if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%0b want=0", instr_valid); end
        n_checks++;
        if (instr !== 32'h0) begin n_errors++; $display("FAIL reset_instr got=%08h want=00000000", instr); end
        n_checks++;
        if (instr_pc !== 32'h0) begin n_errors++; $display("FAIL reset_instr_pc got=%08h want=00000000", instr_pc); end
        n_checks++;
        if (flush !== 1'b0) begin n_errors++; $display("FAIL reset_flush got=%0b want=0", flush); end
        n_checks++;
`ifdef MISALIGN_TRAP_EN
        if (trap !== 1'b0) begin n_errors++; $display("FAIL reset_trap got=%0b want=0", trap); end
        n_checks++;
`endif
        mem_busy = 0; imem_ack = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        if (imem_req !== 1'b0) begin n_errors++; $display("FAIL release_idle_req got=%0b want=0", imem_req); end
        n_checks++;
        cycle();
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_errors++; $display("FAIL first_req req=%0b addr=%08h want req=1 addr=00000000", imem_req, imem_addr);
        end
        n_checks++;
        $display("test_reset done");
    endtask

    task automatic test_sequential();
        int n_req = 0, n_ins = 0;
        do_reset();
        mem_lat = 2;
        instr_ready = 1;
        for (int c = 0; c < 60 && (n_req < 3 || n_ins < 3); c++) begin
            cycle();
            if (mem_new && n_req < 3) begin
                if (imem_addr !== 32'(4 * n_req)) begin
                    n_errors++; $display("FAIL seq_addr%0d got=%08h want=%08h", n_req, imem_addr, 32'(4 * n_req));
                end
                n_checks++;
                n_req++;
            end
            if (pre_ack && n_ins < 3) begin
                if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * n_ins) || instr !== mem_word(32'(4 * n_ins))) begin
                    n_errors++;
                    $display("FAIL seq_instr%0d valid=%0b pc=%08h instr=%08h want 1 %08h %08h",
                             n_ins, instr_valid, instr_pc, instr, 32'(4 * n_ins), mem_word(32'(4 * n_ins)));
                end
                n_checks++;
                $display("fetch pc=%08h instr=%08h", instr_pc, instr);
                n_ins++;
            end
        end
        if (n_req != 3 || n_ins != 3) begin n_errors++; $display("FAIL seq_timeout reqs=%0d instrs=%0d want 3 3", n_req, n_ins); end
        n_checks++;
    endtask

    task automatic test_hold_stall();
        bit ok;
        logic [31:0] s_i, s_pc, s_pa;
        do_reset();
        mem_lat = 1;
        wait_valid(ok);
        if (ok !== 1'b1) begin n_errors++; $display("FAIL stall_timeout valid=%0b want 1", instr_valid); end
        n_checks++;
        s_i = instr; s_pc = instr_pc; s_pa = ProgAddr;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (instr_valid !== 1'b1 || instr !== s_i || instr_pc !== s_pc) begin
                n_errors++; $display("FAIL stall_hold%0d valid=%0b instr=%08h pc=%08h want 1 %08h %08h", k, instr_valid, instr, instr_pc, s_i, s_pc);
            end
            n_checks++;
            if (imem_req !== 1'b0 || ProgAddr !== s_pa) begin
                n_errors++; $display("FAIL stall_req%0d req=%0b pa=%08h want 0 %08h", k, imem_req, ProgAddr, s_pa);
            end
            n_checks++;
        end
        instr_ready = 1;
        cycle();
        instr_ready = 0;
        if (instr_valid !== 1'b0 || ProgAddr !== 32'h4) begin
            n_errors++; $display("FAIL accept valid=%0b pa=%08h want 0 00000004", instr_valid, ProgAddr);
        end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            n_errors++; $display("FAIL accept_req req=%0b addr=%08h want 1 00000004", imem_req, imem_addr);
        end
        n_checks++;
        $display("test_hold_stall done");
    endtask

    task automatic test_branch_hold();
        bit ok;
        do_reset();
        mem_lat = 1;
        wait_valid(ok);
        BranchControl = 1; PCBranchType = 3'b000; EQ = 1; BranchBase = 32'h10; BranchOffset = 32'd40;
        cycle();
        clr_branch();
        if (flush !== 1'b1 || instr_valid !== 1'b0) begin
            n_errors++; $display("FAIL beq_flush flush=%0b valid=%0b want 1 0", flush, instr_valid);
        end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h38 || ProgAddr !== 32'h38) begin
            n_errors++; $display("FAIL beq_target req=%0b addr=%08h pa=%08h want 1 00000038", imem_req, imem_addr, ProgAddr);
        end
        n_checks++;
        cycle();
        if (flush !== 1'b0) begin n_errors++; $display("FAIL beq_pulse flush=%0b want 0", flush); end
        n_checks++;
        wait_valid(ok);
        if (ok !== 1'b1 || instr_pc !== 32'h38 || instr !== mem_word(32'h38)) begin
            n_errors++; $display("FAIL beq_fetch pc=%08h instr=%08h want 00000038 %08h", instr_pc, instr, mem_word(32'h38));
        end
        n_checks++;
        $display("fetch pc=%08h instr=%08h", instr_pc, instr);
    endtask

    task automatic test_not_taken();
        bit ok;
        do_reset();
        mem_lat = 1;
        wait_valid(ok);
        BranchControl = 1; PCBranchType = 3'b110; LTU = 0; LT = 1; BranchBase = 32'h200;
        instr_ready = 1;
        cycle();
        instr_ready = 0;
        if (flush !== 1'b0 || ProgAddr !== 32'h4 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            n_errors++; $display("FAIL bltu_nt flush=%0b pa=%08h req=%0b addr=%08h want 0 4 1 4", flush, ProgAddr, imem_req, imem_addr);
        end
        n_checks++;
        for (int t = 2; t <= 3; t++) begin
            PCBranchType = 3'(t);
            {EQ, NE, LT, LTU, GE, GEU} = 6'b111111;
            wait_valid(ok);
            instr_ready = 1;
            cycle();
            instr_ready = 0;
            if (flush !== 1'b0 || ProgAddr !== 32'(4 * t)) begin
                n_errors++; $display("FAIL code%0d_nt flush=%0b pa=%08h want 0 %08h", t, flush, ProgAddr, 32'(4 * t));
            end
            n_checks++;
        end
        clr_branch();
        $display("test_not_taken done");
    endtask

    task automatic test_drain();
        bit seen;
        do_reset();
        mem_lat = 4;
        instr_ready = 1;
        cycle();
        Jump = 1; BranchBase = 32'h100; BranchOffset = 32'h20;
        cycle();
        clr_branch();
        if (flush !== 1'b1 || imem_req !== 1'b0 || ProgAddr !== 32'h120 || instr_valid !== 1'b0) begin
            n_errors++; $display("FAIL drain_enter flush=%0b req=%0b pa=%08h valid=%0b want 1 0 120 0", flush, imem_req, ProgAddr, instr_valid);
        end
        n_checks++;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (imem_req !== 1'b0) begin n_errors++; $display("FAIL drain_req%0d got=%0b want=0", c, imem_req); end
            n_checks++;
            seen = imem_ack;
            if (!seen) cycle();
        end
        if (seen !== 1'b1) begin n_errors++; $display("FAIL drain_ack_timeout ack=%0b want 1", imem_ack); end
        n_checks++;
        cycle();
        if (instr_valid !== 1'b0 || instr !== 32'h0) begin
            n_errors++; $display("FAIL drain_discard valid=%0b instr=%08h want 0 00000000", instr_valid, instr);
        end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h120) begin
            n_errors++; $display("FAIL drain_refetch req=%0b addr=%08h want 1 00000120", imem_req, imem_addr);
        end
        n_checks++;
        instr_ready = 0;
        wait_valid(seen);
        if (seen !== 1'b1 || instr_pc !== 32'h120 || instr !== mem_word(32'h120)) begin
            n_errors++; $display("FAIL drain_fetch pc=%08h instr=%08h want 00000120 %08h", instr_pc, instr, mem_word(32'h120));
        end
        n_checks++;
        $display("fetch pc=%08h instr=%08h", instr_pc, instr);
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        mem_lat = 1;
        wait_valid(ok);
        Jump = 1; BranchBase = 32'hFFFF_FFFC; BranchOffset = 32'h8;
        cycle();
        clr_branch();
        if (ProgAddr !== 32'h4 || flush !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            n_errors++; $display("FAIL wrap pa=%08h flush=%0b req=%0b addr=%08h want 4 1 1 4", ProgAddr, flush, imem_req, imem_addr);
        end
        n_checks++;
        $display("test_wrap done");
    endtask

`ifdef MISALIGN_TRAP_EN
    task automatic test_misalign();
        bit ok;
        do_reset();
        mem_lat = 1;
        wait_valid(ok);
        Jump = 1; BranchBase = 32'h100; BranchOffset = 32'h2;
        cycle();
        clr_branch();
        if (trap !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || ProgAddr !== 32'h102 || flush !== 1'b1) begin
            n_errors++; $display("FAIL trap_enter trap=%0b req=%0b valid=%0b pa=%08h flush=%0b", trap, imem_req, instr_valid, ProgAddr, flush);
        end
        n_checks++;
        instr_ready = 1;
        for (int k = 0; k < 8; k++) begin
            Jump = k[0]; BranchBase = 32'h400;
            cycle();
            if (imem_req !== 1'b0 || trap !== 1'b1 || ProgAddr !== 32'h102) begin
                n_errors++; $display("FAIL halt%0d req=%0b trap=%0b pa=%08h want 0 1 00000102", k, imem_req, trap, ProgAddr);
            end
            n_checks++;
        end
        do_reset();
        if (trap !== 1'b0) begin n_errors++; $display("FAIL trap_clear got=%0b want=0", trap); end
        n_checks++;
        $display("test_misalign done");
    endtask
`else
    task automatic test_misalign();
        bit ok;
        do_reset();
        mem_lat = 1;
        wait_valid(ok);
        Jump = 1; BranchBase = 32'h101; BranchOffset = 32'h2;
        cycle();
        clr_branch();
        if (ProgAddr !== 32'h100 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            n_errors++; $display("FAIL align_force pa=%08h req=%0b addr=%08h want 100 1 100", ProgAddr, imem_req, imem_addr);
        end
        n_checks++;
        $display("test_misalign done");
    endtask
`endif

    task automatic test_random();
        logic [31:0] exp_pc, a, b, tgt;
        logic [2:0]  ty;
        bit killed, taken, captured, exp_valid, exp_req, br, jp;
        do_reset();
        mem_rand_lat = 1;
        exp_pc = 32'h0;
        killed = 0;
        for (int i = 0; i < 3000; i++) begin
            instr_ready = ($urandom_range(0, 9) < 6);
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            EQ = (a == b); NE = (a != b);
            LT = ($signed(a) < $signed(b)); GE = !LT;
            LTU = (a < b); GEU = !LTU;
            ty = 3'($urandom_range(0, 7));
            jp = ($urandom_range(0, 29) == 0);
            br = ($urandom_range(0, 7) == 0);
            Jump = jp; BranchControl = br; PCBranchType = ty;
            BranchBase = $urandom; BranchOffset = $urandom;
`ifdef MISALIGN_TRAP_EN
            BranchBase[1:0] = 2'b00; BranchOffset[1:0] = 2'b00;
`endif
            taken = jp || (br && branch_ok(ty, a, b));
            tgt = (BranchBase + BranchOffset) & 32'hFFFF_FFFC;
            cycle();
            captured = pre_ack && !taken && !killed;
            if (taken && (pre_busy || pre_ack)) killed = 1;
            if (taken) exp_pc = tgt;
            else if (pre_valid && pre_ready) exp_pc = exp_pc + 32'd4;
            exp_valid = !taken && (captured || (pre_valid && !pre_ready));
            exp_req = !exp_valid && !(pre_busy && killed);
            if (pre_valid && pre_ready && !taken) $display("fetch pc=%08h instr=%08h", pre_ipc, pre_instr);

            if (flush !== taken) begin n_errors++; $display("FAIL rnd_flush c%0d got=%0b want=%0b", i, flush, taken); end
            n_checks++;
            if (ProgAddr !== exp_pc) begin n_errors++; $display("FAIL rnd_pc c%0d got=%08h want=%08h", i, ProgAddr, exp_pc); end
            n_checks++;
            if (instr_valid !== exp_valid) begin n_errors++; $display("FAIL rnd_valid c%0d got=%0b want=%0b", i, instr_valid, exp_valid); end
            n_checks++;
            if (imem_req !== exp_req) begin n_errors++; $display("FAIL rnd_req c%0d got=%0b want=%0b", i, imem_req, exp_req); end
            n_checks++;
            if (exp_req) begin
                if (imem_addr !== exp_pc) begin n_errors++; $display("FAIL rnd_addr c%0d got=%08h want=%08h", i, imem_addr, exp_pc); end
                n_checks++;
            end
            if (exp_valid) begin
                if (captured) begin
                    if (instr !== mem_word(pre_ack_addr) || instr_pc !== pre_ack_addr) begin
                        n_errors++; $display("FAIL rnd_capture c%0d instr=%08h pc=%08h want %08h %08h", i, instr, instr_pc, mem_word(pre_ack_addr), pre_ack_addr);
                    end
                end else begin
                    if (instr !== pre_instr || instr_pc !== pre_ipc) begin
                        n_errors++; $display("FAIL rnd_hold c%0d instr=%08h pc=%08h want %08h %08h", i, instr, instr_pc, pre_instr, pre_ipc);
                    end
                end
                n_checks++;
                if (instr_pc !== exp_pc) begin n_errors++; $display("FAIL rnd_ipc c%0d got=%08h want=%08h", i, instr_pc, exp_pc); end
                n_checks++;
            end
            if (mem_new) killed = 0;
        end
        clr_branch();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_hold_stall();
        test_branch_hold();
        test_not_taken();
        test_drain();
        test_wrap();
        test_misalign();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
